// File: rtl/ste_avg_seq_if.sv
// ADC-side, filter-side and result buses of the averaging sequencer.
// slave: the sequencer. master: the ADC, the filter and the display logic.
interface ste_avg_seq_if #(
  parameter int unsigned DATA_W = 16
);
  logic              adc_valid_i;
  logic [DATA_W-1:0] adc_data_i;
  logic              adc_ready_o;
  logic [DATA_W-1:0] fir_din_o;
  logic              fir_din_update_o;
  logic              fir_dout_update_i;
  logic [DATA_W-1:0] fir_dout_i;
  logic              res_valid_o;
  logic [DATA_W-1:0] res_data_o;
  logic [1:0]        res_mode_o;

  modport slave (
    input  adc_valid_i, adc_data_i, fir_dout_update_i, fir_dout_i,
    output adc_ready_o, fir_din_o, fir_din_update_o, res_valid_o, res_data_o, res_mode_o
  );

  modport master (
    output adc_valid_i, adc_data_i, fir_dout_update_i, fir_dout_i,
    input  adc_ready_o, fir_din_o, fir_din_update_o, res_valid_o, res_data_o, res_mode_o
  );
endinterface

// File: rtl/ste_avg_seq.sv
// Paces ADC samples into the shared moving-average filter, discards warm-up
// outputs after reset/enable/mode change, and watches for a silent filter.
module ste_avg_seq #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AVG_DEPTH = 16,
  parameter int unsigned GAP_CYC   = 2,
  parameter int unsigned TMO_CYC   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic               err_clr_i,
  ste_avg_seq_if.slave       bus,
  output logic               settled_o,
  output logic               err_tmo_o
);

  localparam int unsigned SET_W = $clog2(AVG_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e            state_q;
  logic              rdy_q;
  logic [DATA_W-1:0] fir_din_q;
  logic              fir_upd_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic [1:0]        res_mode_q;
  logic [1:0]        mode_r_q;
  logic [SET_W-1:0]  settle_q;
  logic [SET_W-1:0]  settle_d;
  logic              settled_q;
  logic              err_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;

  logic accept;
  logic mode_chg;
  logic rsp;
  logic tmo;
  logic qualify;

  // rdy_q marks IDLE after the first post-reset edge; en_i gates acceptance directly
  assign accept   = rdy_q & en_i & bus.adc_valid_i;
  assign mode_chg = (mode_i != mode_r_q);
  assign rsp      = (state_q == S_WAIT) & bus.fir_dout_update_i;
  assign tmo      = (state_q == S_WAIT) & ~bus.fir_dout_update_i &
                    (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
  // A response coinciding with a mode change belongs to the old mode: drop it
  assign qualify  = rsp & ~mode_chg & (settle_q == SET_W'(AVG_DEPTH));

  always_comb begin
    settle_d = settle_q;
    if (mode_chg || tmo || ((state_q == S_IDLE) && !en_i)) begin
      settle_d = '0;
    end else if (rsp && (settle_q != SET_W'(AVG_DEPTH))) begin
      settle_d = settle_q + SET_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      fir_din_q   <= '0;
      fir_upd_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_mode_q  <= '0;
      mode_r_q    <= '0;
      settle_q    <= '0;
      settled_q   <= 1'b0;
      err_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      fir_upd_q   <= accept;
      res_valid_q <= qualify;
      settle_q    <= settle_d;
      settled_q   <= (settle_d == SET_W'(AVG_DEPTH));
      mode_r_q    <= mode_i;

      if (accept) begin
        fir_din_q <= bus.adc_data_i;
      end
      if (qualify) begin
        res_data_q <= bus.fir_dout_i;
        res_mode_q <= mode_r_q;
      end

      if (tmo) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_WAIT;
            rdy_q     <= 1'b0;
            tmo_cnt_q <= '0;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (rsp || tmo) begin
            gap_cnt_q <= '0;
            if (GAP_CYC == 0) begin
              state_q <= S_IDLE;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= S_GAP;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.adc_ready_o      = rdy_q & en_i;
  assign bus.fir_din_o        = fir_din_q;
  assign bus.fir_din_update_o = fir_upd_q;
  assign bus.res_valid_o      = res_valid_q;
  assign bus.res_data_o       = res_data_q;
  assign bus.res_mode_o       = res_mode_q;
  assign settled_o            = settled_q;
  assign err_tmo_o            = err_q;

endmodule

// File: tb/tb_ste_avg_seq.sv
// Bench for ste_avg_seq: filter model, result scoreboard and directed scenarios.
module tb_ste_avg_seq;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        mode;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en_i;
  logic [1:0] mode_i;
  logic       err_clr_i;
  logic       settled_o;
  logic       err_tmo_o;

  ste_avg_seq_if #(.DATA_W(DATA_W)) bus ();

  ste_avg_seq #(
    .DATA_W(DATA_W), .AVG_DEPTH(DEPTH), .GAP_CYC(2), .TMO_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .err_clr_i(err_clr_i),
    .bus(bus), .settled_o(settled_o), .err_tmo_o(err_tmo_o)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_res  = 0;
  exp_t sb_q[$];
  exp_t last_exp;

  // filter model controls (written only by the main process)
  bit   flt_on  = 1'b0;
  int   inj_cnt = 0;
  int   clr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Filter model: answers an update one cycle later with dout = din
  bit                pend;
  logic [DATA_W-1:0] pend_d;
  int                inj_seen;
  bit                rsp_counted;
  initial begin
    bus.fir_dout_update_i = 1'b0;
    bus.fir_dout_i        = '0;
    pend = 1'b0; pend_d = '0; inj_seen = 0; rsp_counted = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.fir_dout_update_i = 1'b0;
      rsp_counted = 1'b1;
      if (inj_cnt != inj_seen) begin
        inj_seen = inj_cnt;
        bus.fir_dout_update_i = 1'b1;
        bus.fir_dout_i = 16'hDEAD;
        rsp_counted = 1'b0;
      end else if (pend) begin
        bus.fir_dout_update_i = 1'b1;
        bus.fir_dout_i = pend_d;
      end
      pend = 1'b0;
      if (bus.fir_din_update_o && flt_on) begin
        pend = 1'b1;
        pend_d = bus.fir_din_o;
      end
    end
  end

  // Reference settle tracking + scoreboard compare, on the inactive edge
  int         m_settle = 0;
  logic [1:0] m_mode   = 2'd0;
  int         clr_seen = 0;
  exp_t       got_e;
  always @(negedge clk) begin
    if (rst) begin
      m_settle = 0;
      m_mode   = 2'd0;
      clr_seen = clr_cnt;
    end else begin
      if (bus.res_valid_o) begin
        if (sb_q.size() == 0) begin
          chk("res_unexpected", 32'(bus.res_data_o), 32'hFFFF_FFFF);
        end else begin
          got_e = sb_q.pop_front();
          chk("res_data", 32'(bus.res_data_o), 32'(got_e.data));
          chk("res_mode", 32'(bus.res_mode_o), 32'(got_e.mode));
          last_exp = got_e;
          n_res++;
        end
      end
      if (clr_seen != clr_cnt) begin
        clr_seen = clr_cnt;
        m_settle = 0;
      end
      if (mode_i != m_mode) begin
        m_mode   = mode_i;
        m_settle = 0;
      end else if (bus.fir_dout_update_i && rsp_counted) begin
        if (m_settle < DEPTH) m_settle++;
        else sb_q.push_back('{data: bus.fir_dout_i, mode: m_mode});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one sample and return at #1 after the accepting edge (cycle T+1)
  task automatic send(input logic [DATA_W-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.adc_valid_i = 1'b1;
    bus.adc_data_i  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.adc_ready_o;
      @(posedge clk); #1;
    end
    bus.adc_valid_i = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  int n0, n_rdy, n_upd, last;

  initial begin
    rst = 1'b1; en_i = 1'b1; mode_i = 2'd0; err_clr_i = 1'b0;
    bus.adc_valid_i = 1'b0; bus.adc_data_i = '0;

    // reset and enable
    tick(3);
    @(negedge clk);
    chk("rst_ready", 32'(bus.adc_ready_o), 32'd0);
    chk("rst_upd", 32'(bus.fir_din_update_o), 32'd0);
    chk("rst_res", 32'(bus.res_valid_o), 32'd0);
    chk("rst_settled", 32'(settled_o), 32'd0);
    chk("rst_err", 32'(err_tmo_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready_pre", 32'(bus.adc_ready_o), 32'd0);
    @(negedge clk);
    chk("rel_ready", 32'(bus.adc_ready_o), 32'd1);
    tick(1);

    // settle discard
    flt_on = 1'b1;
    n0 = n_res;
    for (int d = 1; d <= 20; d++) begin
      send(DATA_W'(d));
      if (d == 15 || d == 16) begin
        tick(2);
        @(negedge clk);
        chk(d == 15 ? "settle_15" : "settle_16", 32'(settled_o), (d == 16) ? 32'd1 : 32'd0);
        chk("settle_nores", 32'(n_res - n0), 32'd0);
      end
    end
    tick(6);
    chk("settle_nres", 32'(n_res - n0), 32'd4);
    chk("settle_last", 32'(bus.res_data_o), 32'd20);

    // pacing with adc_valid_i held high
    n_rdy = 0; n_upd = 0; last = -1;
    bus.adc_valid_i = 1'b1;
    bus.adc_data_i  = 16'd300;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.adc_ready_o) n_rdy++;
      if (bus.fir_din_update_o) begin
        if (last >= 0) chk("pace_gap", 32'(c - last), 32'd5);
        last = c;
        n_upd++;
      end
      @(posedge clk); #1;
      bus.adc_data_i = DATA_W'(301 + c);
    end
    bus.adc_valid_i = 1'b0;
    chk("pace_upd", 32'(n_upd), 32'd6);
    chk("pace_rdy", 32'(n_rdy), 32'd6);
    tick(5);

    // mode change coinciding with a response
    send(16'h1234);
    tick(1);
    mode_i = 2'd2;
    tick(1);
    @(negedge clk);
    chk("mode_settled", 32'(settled_o), 32'd0);
    chk("mode_res_mode_hold", 32'(bus.res_mode_o), 32'd0);
    chk("mode_res_data_hold", 32'(bus.res_data_o), 32'(last_exp.data));
    n0 = n_res;
    for (int i = 0; i < 17; i++) send(DATA_W'(16'h200 + i));
    tick(6);
    chk("mode_nres", 32'(n_res - n0), 32'd1);
    chk("mode_res_mode", 32'(bus.res_mode_o), 32'd2);
    chk("mode_res_data", 32'(bus.res_data_o), 32'h210);

    // filter timeout, late response, err clear
    flt_on = 1'b0;
    send(16'h0055);              // now in T+1
    tick(7);                     // T+8
    @(negedge clk);
    chk("tmo_err_early", 32'(err_tmo_o), 32'd0);
    chk("tmo_settled_pre", 32'(settled_o), 32'd1);
    inj_cnt++;                   // late response lands in T+9
    @(posedge clk); #1;          // T+9
    flt_on = 1'b1;
    clr_cnt++;
    bus.adc_valid_i = 1'b1;
    bus.adc_data_i  = 16'h0066;
    @(negedge clk);
    chk("tmo_err", 32'(err_tmo_o), 32'd1);
    chk("tmo_settled", 32'(settled_o), 32'd0);
    chk("tmo_ready_t9", 32'(bus.adc_ready_o), 32'd0);
    @(posedge clk); #1;          // T+10
    @(negedge clk);
    chk("tmo_ready_t10", 32'(bus.adc_ready_o), 32'd0);
    @(posedge clk); #1;          // T+11
    @(negedge clk);
    chk("tmo_ready_t11", 32'(bus.adc_ready_o), 32'd1);
    @(posedge clk); #1;          // T+12
    bus.adc_valid_i = 1'b0;
    @(negedge clk);
    chk("tmo_next_upd", 32'(bus.fir_din_update_o), 32'd1);
    chk("tmo_next_din", 32'(bus.fir_din_o), 32'h66);
    tick(4);
    chk("tmo_err_sticky", 32'(err_tmo_o), 32'd1);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    @(negedge clk);
    chk("tmo_err_clr", 32'(err_tmo_o), 32'd0);
    tick(1);

    // disable while the filter is busy
    send(16'h0077);
    en_i = 1'b0;
    bus.adc_valid_i = 1'b1;
    bus.adc_data_i  = 16'h0099;
    n_rdy = 0; n_upd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.adc_ready_o) n_rdy++;
      if (bus.fir_din_update_o) n_upd++;
    end
    chk("dis_ready", 32'(n_rdy), 32'd0);
    chk("dis_upd", 32'(n_upd), 32'd0);
    @(posedge clk); #1;
    clr_cnt++;
    bus.adc_valid_i = 1'b0;
    en_i = 1'b1;
    n0 = n_res;
    for (int i = 0; i < 17; i++) send(DATA_W'(16'h300 + i));
    tick(6);
    chk("dis_nres", 32'(n_res - n0), 32'd1);
    chk("dis_res_data", 32'(bus.res_data_o), 32'h310);

    // asynchronous reset in the middle of WAIT
    flt_on = 1'b0;
    send(16'h0ABC);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.adc_ready_o), 32'd0);
    chk("arst_upd", 32'(bus.fir_din_update_o), 32'd0);
    chk("arst_din", 32'(bus.fir_din_o), 32'd0);
    chk("arst_res_data", 32'(bus.res_data_o), 32'd0);
    chk("arst_res_mode", 32'(bus.res_mode_o), 32'd0);
    chk("arst_settled", 32'(settled_o), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
